// File: rtl/fusion_feedback_tx.sv
// Fused-estimate return path: captures one 6-state / 6-covariance frame and streams it
// as 12 sixteen-bit words on two independent valid/ready channels (A = sensor 1, B = sensor 2).
module fusion_feedback_tx #(
   parameter int PF_SHIFT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] x0f,
   input  logic [15:0] x1f,
   input  logic [15:0] x2f,
   input  logic [15:0] x3f,
   input  logic [15:0] x4f,
   input  logic [15:0] x5f,
   input  logic [31:0] pf1,
   input  logic [31:0] pf2,
   input  logic [31:0] pf3,
   input  logic [31:0] pf4,
   input  logic [31:0] pf5,
   input  logic [31:0] pf6,
   output logic        a_valid,
   input  logic        a_ready,
   output logic [15:0] a_data,
   output logic [3:0]  a_idx,
   output logic        a_last,
   output logic        b_valid,
   input  logic        b_ready,
   output logic [15:0] b_data,
   output logic [3:0]  b_idx,
   output logic        b_last,
   output logic        sat_flag,
   output logic        busy
);

   // state | meaning
   // IDLE  | no frame held, ready to capture
   // SEND  | frame held, at least one channel still has words outstanding
   typedef enum logic {IDLE, SEND} state_t;

   state_t      state, state_nxt;
   logic [15:0] frame_buf [16];
   logic [3:0]  a_ptr, b_ptr;
   logic        a_done, b_done;
   logic        capture, a_fire, b_fire, a_fin, b_fin;
   logic [31:0] pf_in   [6];
   logic [15:0] pf_nar  [6];
   logic [5:0]  pf_clamp;

   // Returns {clamped, value}: shifted covariance limited to the non-negative 16-bit range.
   function automatic logic [16:0] narrow(input logic [31:0] pf);
      logic signed [31:0] s;
      s = $signed(pf) >>> PF_SHIFT;
      if (s < 32'sd0)
         narrow = {1'b1, 16'h0000};
      else if (s > 32'sd32767)
         narrow = {1'b1, 16'h7fff};
      else
         narrow = {1'b0, s[15:0]};
   endfunction

   assign pf_in[0] = pf1;
   assign pf_in[1] = pf2;
   assign pf_in[2] = pf3;
   assign pf_in[3] = pf4;
   assign pf_in[4] = pf5;
   assign pf_in[5] = pf6;

   always_comb begin
      for (int i = 0; i < 6; i++) begin
         {pf_clamp[i], pf_nar[i]} = narrow(pf_in[i]);
      end
   end

   assign capture = in_valid & in_ready;
   assign a_fire  = ~a_done & a_ready;
   assign b_fire  = ~b_done & b_ready;
   assign a_fin   = a_done | (a_fire & (a_ptr == 4'd11));
   assign b_fin   = b_done | (b_fire & (b_ptr == 4'd11));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid & ~rst) state_nxt = SEND;
         end
         SEND: begin
            if (a_fin & b_fin) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_ptr    <= 4'd0;
         b_ptr    <= 4'd0;
         a_done   <= 1'b1;
         b_done   <= 1'b1;
         sat_flag <= 1'b0;
         for (int i = 0; i < 16; i++) frame_buf[i] <= 16'h0000;
      end else if (capture) begin
         frame_buf[0] <= x0f;
         frame_buf[1] <= x1f;
         frame_buf[2] <= x2f;
         frame_buf[3] <= x3f;
         frame_buf[4] <= x4f;
         frame_buf[5] <= x5f;
         for (int i = 0; i < 6; i++) frame_buf[i+6] <= pf_nar[i];
         sat_flag <= |pf_clamp;
         a_ptr    <= 4'd0;
         b_ptr    <= 4'd0;
         a_done   <= 1'b0;
         b_done   <= 1'b0;
      end else begin
         // pointers park on 11 once done so outputs stay quiet until the next capture
         if (a_fire) begin
            if (a_ptr == 4'd11) a_done <= 1'b1;
            else                a_ptr  <= a_ptr + 4'd1;
         end
         if (b_fire) begin
            if (b_ptr == 4'd11) b_done <= 1'b1;
            else                b_ptr  <= b_ptr + 4'd1;
         end
      end
   end

   assign a_valid = ~a_done;
   assign a_data  = frame_buf[a_ptr];
   assign a_idx   = a_ptr;
   assign a_last  = ~a_done & (a_ptr == 4'd11);
   assign b_valid = ~b_done;
   assign b_data  = frame_buf[b_ptr];
   assign b_idx   = b_ptr;
   assign b_last  = ~b_done & (b_ptr == 4'd11);
   assign busy    = (state == SEND);

endmodule

// File: tb/tb_fusion_feedback_tx.sv
// Scoreboard bench for fusion_feedback_tx: two instances (PF_SHIFT 0 and 4) share stimulus.
module tb_fusion_feedback_tx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        a_ready = 1'b0, b_ready = 1'b0;
   logic [15:0] x_r  [6];
   logic [31:0] pf_r [6];

   logic        in_ready, a_valid, a_last, b_valid, b_last, sat_flag, busy;
   logic [15:0] a_data, b_data;
   logic [3:0]  a_idx, b_idx;
   logic        in_ready4, a_valid4, a_last4, b_valid4, b_last4, sat_flag4, busy4;
   logic [15:0] a_data4, b_data4;
   logic [3:0]  a_idx4, b_idx4;

   int checks = 0, passes = 0, fails = 0;
   int cycle = 0, cap = 0, rmode = 0;
   bit exp_sat0, exp_sat4;
   logic [19:0] qa0[$], qb0[$], qa4[$], qb4[$];

   fusion_feedback_tx #(.PF_SHIFT(0)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x0f(x_r[0]), .x1f(x_r[1]), .x2f(x_r[2]), .x3f(x_r[3]), .x4f(x_r[4]), .x5f(x_r[5]),
      .pf1(pf_r[0]), .pf2(pf_r[1]), .pf3(pf_r[2]), .pf4(pf_r[3]), .pf5(pf_r[4]), .pf6(pf_r[5]),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_idx(a_idx), .a_last(a_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_idx(b_idx), .b_last(b_last),
      .sat_flag(sat_flag), .busy(busy));

   fusion_feedback_tx #(.PF_SHIFT(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .x0f(x_r[0]), .x1f(x_r[1]), .x2f(x_r[2]), .x3f(x_r[3]), .x4f(x_r[4]), .x5f(x_r[5]),
      .pf1(pf_r[0]), .pf2(pf_r[1]), .pf3(pf_r[2]), .pf4(pf_r[3]), .pf5(pf_r[4]), .pf6(pf_r[5]),
      .a_valid(a_valid4), .a_ready(a_ready), .a_data(a_data4), .a_idx(a_idx4), .a_last(a_last4),
      .b_valid(b_valid4), .b_ready(b_ready), .b_data(b_data4), .b_idx(b_idx4), .b_last(b_last4),
      .sat_flag(sat_flag4), .busy(busy4));

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         passes++;
      end
   endtask

   // Covariance word as the sink should see it: floor(pf / 2^sh), limited to 0..32767.
   function automatic int model_cov(input int pf, input int sh, output bit cl);
      int s;
      s  = pf >>> sh;
      cl = 1'b0;
      if (s < 0) begin
         s = 0; cl = 1'b1;
      end else if (s > 32767) begin
         s = 32767; cl = 1'b1;
      end
      return s;
   endfunction

   task automatic push_frame();
      bit c;
      bit s0 = 1'b0, s4 = 1'b0;
      int v;
      logic [19:0] e;
      for (int i = 0; i < 6; i++) begin
         e = {4'(i), x_r[i]};
         qa0.push_back(e); qb0.push_back(e); qa4.push_back(e); qb4.push_back(e);
      end
      for (int i = 0; i < 6; i++) begin
         v = model_cov(int'(pf_r[i]), 0, c); s0 |= c;
         e = {4'(i + 6), 16'(v)};
         qa0.push_back(e); qb0.push_back(e);
         v = model_cov(int'(pf_r[i]), 4, c); s4 |= c;
         e = {4'(i + 6), 16'(v)};
         qa4.push_back(e); qb4.push_back(e);
      end
      exp_sat0 = s0;
      exp_sat4 = s4;
   endtask

   task automatic mon(input int ch, input logic v, input logic r, input logic [15:0] d,
                      input logic [3:0] i, input logic l);
      logic [19:0] e;
      int n;
      if (!v || rst) return;
      case (ch)
         0: n = qa0.size();
         1: n = qb0.size();
         2: n = qa4.size();
         default: n = qb4.size();
      endcase
      if (n == 0) begin
         checks++; fails++;
         $display("FAIL unexpected_beat ch%0d: got idx %0d data %0h expected no beat", ch, i, d);
         return;
      end
      case (ch)
         0: e = qa0[0];
         1: e = qb0[0];
         2: e = qa4[0];
         default: e = qb4[0];
      endcase
      chk($sformatf("beat_ch%0d", ch), 32'({d, i, l}), 32'({e[15:0], e[19:16], e[19:16] == 4'd11}));
      if (r) begin
         case (ch)
            0: void'(qa0.pop_front());
            1: void'(qb0.pop_front());
            2: void'(qa4.pop_front());
            default: void'(qb4.pop_front());
         endcase
      end
   endtask

   always @(negedge clk) begin
      mon(0, a_valid,  a_ready, a_data,  a_idx,  a_last);
      mon(1, b_valid,  b_ready, b_data,  b_idx,  b_last);
      mon(2, a_valid4, a_ready, a_data4, a_idx4, a_last4);
      mon(3, b_valid4, b_ready, b_data4, b_idx4, b_last4);
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         case (rmode)
            0: begin a_ready = 1'b1; b_ready = 1'b1; end
            1: begin
               a_ready = ($urandom_range(0, 9) < 6);
               b_ready = ($urandom_range(0, 9) < 4);
            end
            default: begin a_ready = 1'b1; b_ready = ((cycle - cap) > 20); end
         endcase
      end
   end

   task automatic check_reset(input string name);
      chk({name, "_flags"}, 32'({a_valid, b_valid, a_last, b_last, sat_flag, busy}), 32'd0);
      chk({name, "_data"},  {a_data, b_data}, 32'd0);
      chk({name, "_idx"},   32'({a_idx, b_idx}), 32'd0);
   endtask

   task automatic rand_frame();
      for (int i = 0; i < 6; i++) begin
         x_r[i] = 16'($urandom);
         case ($urandom_range(0, 3))
            0: pf_r[i] = $urandom;
            1: pf_r[i] = 32'($urandom_range(0, 32767));
            2: pf_r[i] = 32'($urandom_range(0, 600000));
            default: pf_r[i] = -32'($urandom_range(1, 1000));
         endcase
      end
   endtask

   task automatic do_capture(input int pre);
      bit ok = 1'b0;
      repeat (pre) @(posedge clk);
      @(posedge clk); #1;
      in_valid = 1'b1;
      for (int t = 0; t < 60 && !ok; t++) begin
         @(negedge clk);
         if (in_ready && !rst) ok = 1'b1;
      end
      if (!ok) begin
         checks++; fails++;
         $display("FAIL capture_timeout: in_ready low, expected high");
      end else begin
         cap = cycle;
         push_frame();
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      rand_frame();
   endtask

   task automatic wait_done(input int end_k);
      bit done = 1'b0;
      int k;
      for (int t = 0; t < 400 && !done; t++) begin
         @(negedge clk);
         k = cycle - cap;
         if (k == 1) begin
            chk("start_flags", 32'({busy, a_valid, b_valid, a_idx, b_idx}), 32'({3'b111, 8'h00}));
            chk("sat_flag", 32'(sat_flag), 32'(exp_sat0));
            chk("sat_flag_shift4", 32'(sat_flag4), 32'(exp_sat4));
         end
         if (!busy) begin
            done = 1'b1;
            chk("in_ready_after_frame", 32'(in_ready), 32'd1);
            if (end_k > 0) chk("frame_length", k, end_k);
         end
      end
      if (!done) begin
         checks++; fails++;
         $display("FAIL busy_timeout: busy still high, expected low");
      end
      chk("queues_drained", qa0.size() + qb0.size() + qa4.size() + qb4.size(), 0);
      qa0.delete(); qb0.delete(); qa4.delete(); qb4.delete();
   endtask

   initial begin
      int xv[6]  = '{100, -200, 300, -400, 500, -600};
      int pv[6]  = '{1234, 1, 0, 32767, 2, 3};
      int sv[6]  = '{40000, -5, 32768, 10, 20, 30};
      int hv[6]  = '{65536, 15, 100, 200, 300, 400};
      bit ok;

      for (int i = 0; i < 6; i++) begin x_r[i] = 16'(xv[i]); pf_r[i] = 32'(pv[i]); end
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("in_ready_in_rst", 32'(in_ready), 32'd0);
      check_reset("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);
      chk("busy_after_rst", 32'(busy), 32'd0);

      rmode = 0;
      do_capture(0);
      wait_done(13);

      for (int i = 0; i < 6; i++) pf_r[i] = 32'(sv[i]);
      do_capture(0);
      wait_done(13);

      for (int i = 0; i < 6; i++) pf_r[i] = 32'(hv[i]);
      do_capture(0);
      wait_done(13);

      rmode = 2;
      rand_frame();
      do_capture(0);
      wait_done(33);

      rmode = 1;
      for (int f = 0; f < 50; f++) begin
         rand_frame();
         do_capture($urandom_range(0, 3));
         wait_done(0);
      end

      // reset in the middle of a frame while the source keeps in_valid asserted
      rmode = 0;
      rand_frame();
      @(posedge clk); #1;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 60 && !ok; t++) begin
         @(negedge clk);
         if (in_ready && !rst) ok = 1'b1;
      end
      chk("rst_test_capture", 32'(ok), 32'd1);
      cap = cycle;
      push_frame();
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      qa0.delete(); qb0.delete(); qa4.delete(); qb4.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset("mid_rst");
      chk("in_ready_after_mid_rst", 32'(in_ready), 32'd1);
      cap = cycle;
      push_frame();
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done(13);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
